// File: rtl/alien_pkg.sv
// Shared types and defaults for the alien matrix centre scanner.
package alien_pkg;

    localparam int COORD_W = 11;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } scan_state_t;

    // Index width that stays legal for single-entry dimensions.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alien_cell_center.sv
// Combinational centre of one alien cell: TL + cell offset + half a cell, wrapping at COORD_W bits.
module alien_cell_center
#(
    parameter int CELL_BITS = 5,
    parameter int COORD_W   = alien_pkg::COORD_W,
    parameter int COL_W     = 3,
    parameter int ROW_W     = 2
)(
    input  logic [COORD_W-1:0] tlx,
    input  logic [COORD_W-1:0] tly,
    input  logic [COL_W-1:0]   col,
    input  logic [ROW_W-1:0]   row,
    output logic [COORD_W-1:0] cx,
    output logic [COORD_W-1:0] cy
);

    localparam logic [COORD_W-1:0] HALF = COORD_W'(1) << (CELL_BITS - 1);

    always_comb begin
        cx = tlx + (COORD_W'(col) << CELL_BITS) + HALF;
        cy = tly + (COORD_W'(row) << CELL_BITS) + HALF;
    end

endmodule

// File: rtl/alien_center_scan.sv
// Walks the alien matrix row-major, presenting each cell centre over a valid/ready handshake.
// Define ALIEN_SCAN_SKIP_DEAD_EN to suppress valid on dead cells (each still costs one cycle).
module alien_center_scan
    import alien_pkg::*;
#(
    parameter int CELL_BITS = 5,
    parameter int COLS      = 8,
    parameter int ROWS      = 4,
    parameter int COORD_W   = alien_pkg::COORD_W,
    localparam int COL_W    = alien_pkg::idx_w(COLS),
    localparam int ROW_W    = alien_pkg::idx_w(ROWS)
)(
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 start,
    input  logic [COORD_W-1:0]   alienMatrixTLX,
    input  logic [COORD_W-1:0]   alienMatrixTLY,
    input  logic [ROWS*COLS-1:0] aliveMask,
    input  logic                 centerReady,
    output logic                 centerValid,
    output logic [COORD_W-1:0]   centerX,
    output logic [COORD_W-1:0]   centerY,
    output logic [COL_W-1:0]     centerCol,
    output logic [ROW_W-1:0]     centerRow,
    output logic                 centerAlive,
    output logic                 busy,
    output logic                 done
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    scan_state_t          state, state_nx;
    logic [COORD_W-1:0]   tlx_q, tly_q, sel_tlx, sel_tly, cx, cy;
    logic [ROWS*COLS-1:0] mask_q;
    logic [COL_W-1:0]     col_nx;
    logic [ROW_W-1:0]     row_nx;
    logic                 advance, last, start_ok, nxt_alive;

    // The registered outputs double as the scan index; one centre unit
    // serves both the start load (live inputs) and every later step (latched TL).
    alien_cell_center #(
        .CELL_BITS (CELL_BITS),
        .COORD_W   (COORD_W),
        .COL_W     (COL_W),
        .ROW_W     (ROW_W)
    ) u_center (
        .tlx (sel_tlx),
        .tly (sel_tly),
        .col (col_nx),
        .row (row_nx),
        .cx  (cx),
        .cy  (cy)
    );

    always_comb begin
        state_nx  = state;
        col_nx    = centerCol;
        row_nx    = centerRow;
        sel_tlx   = tlx_q;
        sel_tly   = tly_q;
        nxt_alive = mask_q[1];
        start_ok  = 1'b0;
        advance   = 1'b0;
        last      = (centerCol == COL_LAST) && (centerRow == ROW_LAST);
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx  = SCAN;
                    start_ok  = 1'b1;
                    col_nx    = '0;
                    row_nx    = '0;
                    sel_tlx   = alienMatrixTLX;
                    sel_tly   = alienMatrixTLY;
                    nxt_alive = aliveMask[0];
                end
            end
            SCAN: begin
                // A cell without valid (dead, in skip builds) retires on its own.
                advance = centerReady || !centerValid;
                if (advance) begin
                    if (last) begin
                        state_nx = DONE;
                    end else if (centerCol == COL_LAST) begin
                        col_nx = '0;
                        row_nx = centerRow + ROW_W'(1);
                    end else begin
                        col_nx = centerCol + COL_W'(1);
                    end
                end
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state       <= IDLE;
            tlx_q       <= '0;
            tly_q       <= '0;
            mask_q      <= '0;
            centerValid <= 1'b0;
            centerX     <= '0;
            centerY     <= '0;
            centerCol   <= '0;
            centerRow   <= '0;
            centerAlive <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx != IDLE);
            done  <= (state == SCAN) && (state_nx == DONE);
            if (start_ok) begin
                tlx_q  <= alienMatrixTLX;
                tly_q  <= alienMatrixTLY;
                mask_q <= aliveMask;
            end else if (advance) begin
                mask_q <= mask_q >> 1;
            end
            if (start_ok || (advance && !last)) begin
                centerX     <= cx;
                centerY     <= cy;
                centerCol   <= col_nx;
                centerRow   <= row_nx;
                centerAlive <= nxt_alive;
`ifdef ALIEN_SCAN_SKIP_DEAD_EN
                centerValid <= nxt_alive;
`else
                centerValid <= 1'b1;
`endif
            end else if (advance && last) begin
                centerValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alien_center_scan.sv
// Self-checking bench for alien_center_scan against a row-major list-of-cells reference.
module tb_alien_center_scan;

    localparam int CELL_BITS = 5;
    localparam int COLS      = 8;
    localparam int ROWS      = 4;
    localparam int COORD_W   = 11;
    localparam int N         = ROWS * COLS;
`ifdef ALIEN_SCAN_SKIP_DEAD_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 resetN, start, centerReady;
    logic [COORD_W-1:0]   alienMatrixTLX, alienMatrixTLY;
    logic [N-1:0]         aliveMask;
    logic                 centerValid, centerAlive, busy, done;
    logic [COORD_W-1:0]   centerX, centerY;
    logic [2:0]           centerCol;
    logic [1:0]           centerRow;

    int ncmp  = 0;
    int nfail = 0;

    typedef struct {
        int x;
        int y;
        int col;
        int row;
        int alive;
    } cell_t;

    always #5 clk = ~clk;

    alien_center_scan #(
        .CELL_BITS (CELL_BITS),
        .COLS      (COLS),
        .ROWS      (ROWS),
        .COORD_W   (COORD_W)
    ) dut (
        .clk            (clk),
        .resetN         (resetN),
        .start          (start),
        .alienMatrixTLX (alienMatrixTLX),
        .alienMatrixTLY (alienMatrixTLY),
        .aliveMask      (aliveMask),
        .centerReady    (centerReady),
        .centerValid    (centerValid),
        .centerX        (centerX),
        .centerY        (centerY),
        .centerCol      (centerCol),
        .centerRow      (centerRow),
        .centerAlive    (centerAlive),
        .busy           (busy),
        .done           (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_valid"}, centerValid, 0);
        chk({tag, "_x"}, centerX, 0);
        chk({tag, "_y"}, centerY, 0);
        chk({tag, "_col"}, centerCol, 0);
        chk({tag, "_row"}, centerRow, 0);
        chk({tag, "_alive"}, centerAlive, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    // mode 0: ready always high; 1: random ready; 2: ready low for the first 3 cycles.
    task automatic run_scan(input int tlx, input int tly, input logic [N-1:0] mask, input int mode);
        cell_t       q[$];
        cell_t       e;
        int          n, dones;
        bit          held, fin;
        logic [31:0] hx, hy, hc, hr, ha;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                e.col   = c;
                e.row   = r;
                e.alive = mask[r*COLS + c] ? 1 : 0;
                e.x     = (tlx + c * (1 << CELL_BITS) + (1 << (CELL_BITS - 1))) % (1 << COORD_W);
                e.y     = (tly + r * (1 << CELL_BITS) + (1 << (CELL_BITS - 1))) % (1 << COORD_W);
                if (!SKIP || e.alive == 1) q.push_back(e);
            end
        end
        @(negedge clk);
        alienMatrixTLX = COORD_W'(tlx);
        alienMatrixTLY = COORD_W'(tly);
        aliveMask      = mask;
        centerReady    = 1'b1;
        start          = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0; dones = 0; held = 0; fin = 0;
        hx = 0; hy = 0; hc = 0; hr = 0; ha = 0;
        while (!fin) begin
            @(negedge clk);
            alienMatrixTLX = COORD_W'($urandom);
            alienMatrixTLY = COORD_W'($urandom);
            aliveMask      = $urandom;
            case (mode)
                0:       centerReady = 1'b1;
                1:       centerReady = ($urandom_range(0, 3) != 0);
                default: centerReady = (n >= 3);
            endcase
            if (dones > 0) begin
                start = 1'b0;
                chk("done_single_cycle", done, 0);
                chk("busy_after_done", busy, 0);
                chk("valid_after_done", centerValid, 0);
                fin = 1;
            end else begin
                start = ($urandom_range(0, 5) == 0);
                chk("busy_scan", busy, 1);
                if (n == 0 && !SKIP) chk("valid_first_cycle", centerValid, 1);
                if (held) begin
                    chk("hold_x", centerX, hx);
                    chk("hold_y", centerY, hy);
                    chk("hold_col", centerCol, hc);
                    chk("hold_row", centerRow, hr);
                    chk("hold_alive", centerAlive, ha);
                    chk("hold_valid", centerValid, 1);
                end
                held = 0;
                if (centerValid) begin
                    if (q.size() == 0) begin
                        chk("valid_after_last", centerValid, 0);
                    end else if (centerReady) begin
                        e = q.pop_front();
                        chk("cell_x", centerX, e.x);
                        chk("cell_y", centerY, e.y);
                        chk("cell_col", centerCol, e.col);
                        chk("cell_row", centerRow, e.row);
                        chk("cell_alive", centerAlive, e.alive);
                    end else begin
                        held = 1;
                        hx = centerX; hy = centerY; hc = centerCol;
                        hr = centerRow; ha = centerAlive;
                    end
                end
                if (done) begin
                    dones++;
                    chk("cells_left_at_done", q.size(), 0);
                    chk("valid_at_done", centerValid, 0);
                    if (mode == 0) chk("done_cycle", n, N);
                    start = 1'b1;
                end
                n++;
                if (n > 40 * N) begin
                    chk("scan_timeout", done, 1);
                    fin = 1;
                end
            end
        end
        repeat (3) begin
            @(negedge clk);
            chk("idle_no_restart", busy, 0);
            chk("idle_no_done", done, 0);
        end
    endtask

    initial begin
        resetN         = 1'b0;
        start          = 1'b0;
        centerReady    = 1'b0;
        alienMatrixTLX = COORD_W'($urandom);
        alienMatrixTLY = COORD_W'($urandom);
        aliveMask      = $urandom;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_cleared("reset");
        resetN = 1'b1;

        run_scan(100, 50, '1, 0);
        run_scan(100, 50, '1, 2);
        run_scan(2040, 0, '1, 0);

        // Abort a scan at cell 5 with reset, then confirm a clean re-run.
        @(negedge clk);
        alienMatrixTLX = 11'd100;
        alienMatrixTLY = 11'd50;
        aliveMask      = '1;
        centerReady    = 1'b1;
        start          = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 20 && !(centerValid && centerCol == 3'd5 && centerRow == 2'd0); i++)
            @(negedge clk);
        chk("reached_cell5", centerCol, 5);
        resetN = 1'b0;
        @(negedge clk);
        chk_cleared("midscan_reset");
        resetN = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
            chk("abort_idle", busy, 0);
        end
        run_scan(100, 50, '1, 0);

        run_scan(100, 50, 32'h0000_0020, 0);
        run_scan(100, 50, '0, 0);
        run_scan(1900, 2000, 32'h8000_0001, 1);

        for (int k = 0; k < 6; k++)
            run_scan($urandom_range(0, 2047), $urandom_range(0, 2047), $urandom, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/alien_center_scan.md
ALIEN_CENTER_SCAN -- requirements
Module: alien_center_scan

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning):
- CELL_BITS, 5, log2 of cell pitch in pixels (32 px)
- COLS, 8, alien columns
- ROWS, 4, alien rows
- COORD_W, 11, coordinate width
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock
- resetN, in, 1, synchronous active-low reset
- start, in, 1, scan request pulse
- alienMatrixTLX, in, COORD_W, matrix top-left X
- alienMatrixTLY, in, COORD_W, matrix top-left Y
- aliveMask, in, ROWS*COLS, bit r*COLS+c set = alien alive
- centerReady, in, 1, consumer accepts
- centerValid, out, 1, center output valid
- centerX, out, COORD_W, cell centre X
- centerY, out, COORD_W, cell centre Y
- centerCol, out, clog2(COLS), cell column
- centerRow, out, clog2(ROWS), cell row
- centerAlive, out, 1, aliveMask bit of the cell
- busy, out, 1, scan in progress
- done, out, 1, one-cycle end-of-scan pulse
REQ-003 One clock (clk); reset is synchronous and active-low (resetN).

Function
REQ-004 The FSM SHALL have three states: IDLE, SCAN, DONE.
- IDLE -> SCAN on start.
- SCAN -> DONE after the last cell is consumed.
- DONE -> IDLE unconditionally after one cycle.
REQ-005 On start in IDLE, the block SHALL latch TLX, TLY and aliveMask and set the index to row 0, col 0.
- Later input changes SHALL NOT affect the running scan.
REQ-006 Cells SHALL be visited in row-major order: col increments first and wraps to 0 with row+1.
REQ-007 Centre computation:
- centerX = TLX + (col << CELL_BITS) + 2^(CELL_BITS-1)
- centerY = TLY + (row << CELL_BITS) + 2^(CELL_BITS-1)
- Result is truncated to COORD_W bits (modulo 2^COORD_W wrap, no saturation).
REQ-008 All outputs SHALL be registered.
- centerValid rises the cycle after start is sampled.
REQ-009 Handshake:
- While centerValid=1 and centerReady=0, all center* outputs SHALL hold stable.
- A transfer occurs on centerValid&&centerReady.
- The next cell is presented the following cycle (one cell per cycle at full throughput).
REQ-010 After the transfer of cell ROWS*COLS-1:
- centerValid SHALL drop.
- State goes to DONE and done=1 for exactly one cycle.
REQ-011 busy SHALL be 1 in SCAN and DONE, and 0 in IDLE.
REQ-012 start SHALL be ignored while busy=1, including in the cycle of the last transfer and in DONE.

Reset
REQ-013 When resetN=0 at a clk edge, all of the following SHALL be cleared:
- State returns to IDLE.
- centerValid, busy, done, centerAlive go to 0.
- centerX, centerY, centerCol, centerRow go to 0.
- Latched TL and mask go to 0.
REQ-014 Reset mid-scan SHALL abort the scan without a done pulse; a new start is required.

Configuration
REQ-015 Macro ALIEN_SCAN_SKIP_DEAD_EN:
- Defined: dead cells SHALL NOT assert centerValid; each dead cell consumes one cycle. An all-zero mask yields no transfers and done ROWS*COLS+1 cycles after start.
- Undefined: every cell SHALL be presented, with centerAlive reporting its mask bit.

Structure
REQ-016 Package alien_pkg SHALL hold:
- COORD_W default
- coord_t typedef (logic [COORD_W-1:0])
- scan_state_t enum {IDLE, SCAN, DONE}
REQ-017 Sub-module alien_cell_center:
- Combinational; inputs TL, row, col; output centre per REQ-007.
- alien_center_scan SHALL instantiate it once.

Verification
REQ-018 Defaults, TL=(100,50), mask all ones, ready=1 -> first output (116,66) col0 row0; output 10 (row1, col2) = (180,98); 32 transfers then a single done pulse.
REQ-019 ready low for 3 cycles while cell (0,0) is valid -> outputs stable for those 3 cycles; cell (1,0) appears at (148,66) the cycle after ready returns.
REQ-020 TL=(2040,0), col 1 -> centerX = (2040+32+16) mod 2048 = 40.
REQ-021 resetN=0 during cell 5 -> next cycle all outputs 0 and busy=0; no done pulse; start re-runs from (116,66).
REQ-022 With ALIEN_SCAN_SKIP_DEAD_EN and mask=0x20 -> single transfer col5 row0 (276,66); done 33 cycles after start.
REQ-023 start pulsed during SCAN and during DONE -> ignored; exactly one done per accepted start.
